// File: rtl/qchan_power_sequencer.sv
// qchan_power_sequencer
//   Q-channel low-power controller for NUM_DEV devices sharing one
//   low-power request. Devices are quiesced one at a time in ascending
//   index order and woken in descending order. A device's clock gate is
//   closed only after its qacceptn handshake completes, and it is reopened
//   before its qreqn is released. A stuck handshake raises a sticky error
//   while the sequencer keeps waiting.
//
// Ports
//   clk              single clock
//   reset            asynchronous, active-low reset
//   low_power_req_i  level request to enter low power
//   sleep_mask_i     devices to quiesce, sampled when leaving RUN
//   clr_err_i        clears timeout_err_o
//   qactive_i        per-device activity (async, synchronized here)
//   qacceptn_i       per-device acceptance, active-low (async, synchronized)
//   qreqn_o          per-device quiescence request, active-low, registered
//   icg_enable_o     per-device clock-gate enable, registered
//   stopped_o        devices currently quiesced
//   lp_state_o       0 RUN, 1 QREQ, 2 GATE, 3 SLEEP, 4 UNGATE, 5 QEXIT
//   timeout_err_o    sticky handshake timeout flag
//   err_dev_o        device index that caused the recorded timeout
module qchan_power_sequencer #(
  parameter int NUM_DEV        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ICG_DELAY      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               low_power_req_i,
  input  logic [NUM_DEV-1:0] sleep_mask_i,
  input  logic               clr_err_i,
  input  logic [NUM_DEV-1:0] qactive_i,
  input  logic [NUM_DEV-1:0] qacceptn_i,
  output logic [NUM_DEV-1:0] qreqn_o,
  output logic [NUM_DEV-1:0] icg_enable_o,
  output logic [NUM_DEV-1:0] stopped_o,
  output logic [2:0]         lp_state_o,
  output logic               timeout_err_o,
  output logic [2:0]         err_dev_o
);

  localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int DW = $clog2(ICG_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_QREQ   = 3'd1,
    ST_GATE   = 3'd2,
    ST_SLEEP  = 3'd3,
    ST_UNGATE = 3'd4,
    ST_QEXIT  = 3'd5
  } state_t;

  // Synchronizers: acceptance presets to "not accepted", activity to idle.
  logic [NUM_DEV-1:0] qa_pipe [SYNC_STAGES];
  logic [NUM_DEV-1:0] qx_pipe [SYNC_STAGES];
  logic [NUM_DEV-1:0] qa_s, qx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        qa_pipe[s] <= '1;
        qx_pipe[s] <= '0;
      end
    end else begin
      qa_pipe[0] <= qacceptn_i;
      qx_pipe[0] <= qactive_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        qa_pipe[s] <= qa_pipe[s-1];
        qx_pipe[s] <= qx_pipe[s-1];
      end
    end
  end

  assign qa_s = qa_pipe[SYNC_STAGES-1];
  assign qx_s = qx_pipe[SYNC_STAGES-1];

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [NUM_DEV-1:0] mask_reg, mask_next;
  logic [NUM_DEV-1:0] stopped_reg, stopped_next;
  logic [NUM_DEV-1:0] qreqn_reg, qreqn_next;
  logic [NUM_DEV-1:0] icg_reg, icg_next;
  logic [DW-1:0]      dcnt_reg, dcnt_next;
  logic [TW-1:0]      tcnt_reg, tcnt_next;
  logic               err_reg, err_next;
  logic [2:0]         err_dev_reg, err_dev_next;
  logic               t_fire;

  function automatic logic [IW-1:0] lowest_set(input logic [NUM_DEV-1:0] v);
    lowest_set = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--)
      if (v[i]) lowest_set = IW'(i);
  endfunction

  function automatic logic [IW-1:0] highest_set(input logic [NUM_DEV-1:0] v);
    highest_set = '0;
    for (int i = 0; i < NUM_DEV; i++)
      if (v[i]) highest_set = IW'(i);
  endfunction

  // Captured-mask devices above the current index: the next ones to quiesce.
  logic [NUM_DEV-1:0] above_mask;
  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_above
      assign above_mask[gi] = mask_reg[gi] && (gi > int'(idx_reg));
    end
  endgenerate

  logic dly_done;
  logic run_ok;
  logic wake;
  logic [NUM_DEV-1:0] remaining;

  assign dly_done = (dcnt_reg == DW'(ICG_DELAY - 1));
  assign run_ok   = low_power_req_i && (|sleep_mask_i) && !(|(sleep_mask_i & qx_s));
  assign wake     = |(stopped_reg & qx_s);

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    mask_next    = mask_reg;
    stopped_next = stopped_reg;
    qreqn_next   = qreqn_reg;
    icg_next     = icg_reg;
    dcnt_next    = '0;
    tcnt_next    = '0;
    t_fire       = 1'b0;
    remaining    = stopped_reg;
    remaining[idx_reg] = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (run_ok) begin
          mask_next  = sleep_mask_i;
          idx_next   = lowest_set(sleep_mask_i);
          qreqn_next[lowest_set(sleep_mask_i)] = 1'b0;
          state_next = ST_QREQ;
        end
      end
      ST_QREQ: begin
        if (!qa_s[idx_reg]) begin
          stopped_next[idx_reg] = 1'b1;
          if (low_power_req_i) begin
            state_next = ST_GATE;
          end else begin
            // Abort after acceptance: release the request, clock never gated.
            qreqn_next[idx_reg] = 1'b1;
            state_next = ST_QEXIT;
          end
        end else begin
          t_fire    = (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));
          tcnt_next = (tcnt_reg == TW'(TIMEOUT_CYCLES)) ? tcnt_reg : tcnt_reg + TW'(1);
        end
      end
      ST_GATE: begin
        if (!low_power_req_i) begin
          icg_next[idx_reg] = 1'b1;
          state_next = ST_UNGATE;
        end else if (dly_done) begin
          icg_next[idx_reg] = 1'b0;
          if (|above_mask) begin
            idx_next   = lowest_set(above_mask);
            qreqn_next[lowest_set(above_mask)] = 1'b0;
            state_next = ST_QREQ;
          end else begin
            state_next = ST_SLEEP;
          end
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      ST_SLEEP: begin
        if (!low_power_req_i || wake) begin
          idx_next   = highest_set(stopped_reg);
          icg_next[highest_set(stopped_reg)] = 1'b1;
          state_next = ST_UNGATE;
        end
      end
      ST_UNGATE: begin
        if (dly_done) begin
          qreqn_next[idx_reg] = 1'b1;
          state_next = ST_QEXIT;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      ST_QEXIT: begin
        if (qa_s[idx_reg]) begin
          stopped_next[idx_reg] = 1'b0;
          if (|remaining) begin
            idx_next   = highest_set(remaining);
            icg_next[highest_set(remaining)] = 1'b1;
            state_next = ST_UNGATE;
          end else begin
            state_next = ST_RUN;
          end
        end else begin
          t_fire    = (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));
          tcnt_next = (tcnt_reg == TW'(TIMEOUT_CYCLES)) ? tcnt_reg : tcnt_reg + TW'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // A fresh timeout takes priority over a clear issued in the same cycle.
  always_comb begin
    err_next     = err_reg;
    err_dev_next = err_dev_reg;
    if (t_fire && (!err_reg || clr_err_i)) begin
      err_next     = 1'b1;
      err_dev_next = 3'(idx_reg);
    end else if (clr_err_i) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      idx_reg     <= '0;
      mask_reg    <= '0;
      stopped_reg <= '0;
      qreqn_reg   <= '1;
      icg_reg     <= '1;
      dcnt_reg    <= '0;
      tcnt_reg    <= '0;
      err_reg     <= 1'b0;
      err_dev_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      mask_reg    <= mask_next;
      stopped_reg <= stopped_next;
      qreqn_reg   <= qreqn_next;
      icg_reg     <= icg_next;
      dcnt_reg    <= dcnt_next;
      tcnt_reg    <= tcnt_next;
      err_reg     <= err_next;
      err_dev_reg <= err_dev_next;
    end
  end

  assign qreqn_o       = qreqn_reg;
  assign icg_enable_o  = icg_reg;
  assign stopped_o     = stopped_reg;
  assign lp_state_o    = state_reg;
  assign timeout_err_o = err_reg;
  assign err_dev_o     = err_dev_reg;

endmodule

// File: tb/tb_qchan_power_sequencer.sv
// tb_qchan_power_sequencer
//   Directed bench for qchan_power_sequencer (4 devices, default timing).
//   A small device responder answers each qreqn change on qacceptn after a
//   few cycles; individual devices can be silenced to hold a handshake.
module tb_qchan_power_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         lpr;
  logic [N-1:0] mask;
  logic         clr;
  logic [N-1:0] qactive;
  logic [N-1:0] qacceptn;
  logic [N-1:0] qreqn_o, icg_enable_o, stopped_o;
  logic [2:0]   lp_state_o;
  logic         timeout_err_o;
  logic [2:0]   err_dev_o;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] dev_en = '1;
  int           acc_cnt [N];
  logic         watch_icg1 = 1'b0;
  logic         icg1_fell  = 1'b0;

  always #5 clk = ~clk;

  qchan_power_sequencer #(
    .NUM_DEV(N), .SYNC_STAGES(2), .ICG_DELAY(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .low_power_req_i(lpr),
    .sleep_mask_i(mask),
    .clr_err_i(clr),
    .qactive_i(qactive),
    .qacceptn_i(qacceptn),
    .qreqn_o(qreqn_o),
    .icg_enable_o(icg_enable_o),
    .stopped_o(stopped_o),
    .lp_state_o(lp_state_o),
    .timeout_err_o(timeout_err_o),
    .err_dev_o(err_dev_o)
  );

  // Device responder: qacceptn follows qreqn three clocks later when enabled.
  initial begin
    qacceptn = '1;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (dev_en[i] && (qacceptn[i] != qreqn_o[i])) begin
          acc_cnt[i]++;
          if (acc_cnt[i] >= 3) begin
            qacceptn[i] = qreqn_o[i];
            acc_cnt[i]  = 0;
          end
        end else begin
          acc_cnt[i] = 0;
        end
      end
    end
  end

  always @(negedge clk)
    if (watch_icg1 && !icg_enable_o[1]) icg1_fell <= 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] ok %s = %0h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic pick(input int sel, input int b);
    case (sel)
      0:       return qreqn_o[b];
      1:       return icg_enable_o[b];
      default: return stopped_o[b];
    endcase
  endfunction

  task automatic wait_bit(input int sel, input int b, input logic v, input string tag);
    int n = 0;
    while ((pick(sel, b) !== v) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check(tag, pick(sel, b), v);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while ((lp_state_o !== s) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check(tag, lp_state_o, s);
  endtask

  int           devs_fwd [3] = '{0, 1, 3};
  logic [N-1:0] pat_fwd  [3] = '{4'b1110, 4'b1100, 4'b0100};
  int           devs_rev [3] = '{3, 1, 0};

  initial begin
    reset = 1'b0; lpr = 1'b0; mask = '0; clr = 1'b0; qactive = '0;
    tick(3);
    check("rst_state", lp_state_o, 0);
    check("rst_qreqn", qreqn_o, 4'hF);
    check("rst_icg", icg_enable_o, 4'hF);
    check("rst_stopped", stopped_o, 0);
    check("rst_err", timeout_err_o, 0);
    check("rst_errdev", err_dev_o, 0);
    reset = 1'b1;
    tick(2);

    // Requests that must not leave RUN.
    lpr = 1'b1; mask = '0;
    tick(6);
    check("mask0_state", lp_state_o, 0);
    check("mask0_qreqn", qreqn_o, 4'hF);
    lpr = 1'b0; qactive = 4'b0001;
    tick(4);
    mask = 4'b1011; lpr = 1'b1;
    tick(6);
    check("active_state", lp_state_o, 0);
    check("active_qreqn", qreqn_o, 4'hF);
    lpr = 1'b0; qactive = '0;
    tick(4);

    // Ascending quiesce of devices 0, 1, 3.
    mask = 4'b1011; lpr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_bit(0, devs_fwd[k], 1'b0, "qreq_fall");
      check("qreq_order", qreqn_o, pat_fwd[k]);
      check("qreq_state", lp_state_o, 1);
      wait_bit(2, devs_fwd[k], 1'b1, "stopped_set");
      check("icg_hold0", icg_enable_o[devs_fwd[k]], 1);
      tick(1);
      check("icg_hold1", icg_enable_o[devs_fwd[k]], 1);
      tick(1);
      check("icg_drop", icg_enable_o[devs_fwd[k]], 0);
    end
    check("sleep_state", lp_state_o, 3);
    check("sleep_qreqn", qreqn_o, 4'b0100);
    check("sleep_icg", icg_enable_o, 4'b0100);
    check("sleep_stopped", stopped_o, 4'b1011);

    // Wake-up via device 1 activity: descending restore 3, 1, 0.
    qactive = 4'b0010;
    tick(2);
    check("wake_sync_lag", lp_state_o, 3);
    tick(1);
    check("wake_state", lp_state_o, 4);
    for (int k = 0; k < 3; k++) begin
      wait_bit(1, devs_rev[k], 1'b1, "icg_rise");
      check("ungate_state", lp_state_o, 4);
      check("ungate_qreqn0", qreqn_o[devs_rev[k]], 0);
      tick(1);
      check("ungate_qreqn1", qreqn_o[devs_rev[k]], 0);
      tick(1);
      check("qexit_qreqn", qreqn_o[devs_rev[k]], 1);
      check("qexit_state", lp_state_o, 5);
      wait_bit(2, devs_rev[k], 1'b0, "stop_clr");
    end
    wait_state(0, "wake_run");
    check("wake_stopped", stopped_o, 0);
    check("wake_qreqn", qreqn_o, 4'hF);
    check("wake_icg", icg_enable_o, 4'hF);
    tick(3);
    check("run_blocked", lp_state_o, 0);
    lpr = 1'b0; qactive = '0;
    tick(4);

    // Abort while device 1 waits for acceptance.
    mask = 4'b0011; lpr = 1'b1;
    wait_bit(0, 1, 1'b0, "abort_qreq1");
    lpr = 1'b0; dev_en[1] = 1'b0; watch_icg1 = 1'b1;
    tick(6);
    check("abort_hold_state", lp_state_o, 1);
    check("abort_hold_qreqn", qreqn_o[1], 0);
    dev_en[1] = 1'b1;
    wait_state(5, "abort_qexit");
    check("abort_stopped", stopped_o, 4'b0011);
    check("abort_icg", icg_enable_o, 4'b1110);
    check("abort_qreqn", qreqn_o, 4'b1110);
    wait_bit(1, 0, 1'b1, "abort_ungate0");
    check("abort_ungate_state", lp_state_o, 4);
    wait_state(0, "abort_run");
    check("abort_end_icg", icg_enable_o, 4'hF);
    check("abort_end_qreqn", qreqn_o, 4'hF);
    check("abort_end_stopped", stopped_o, 0);
    watch_icg1 = 1'b0;
    check("abort_icg1_never_fell", icg1_fell, 0);

    // Timeout on device 2, late acceptance, then clear.
    dev_en[2] = 1'b0; mask = 4'b0100; lpr = 1'b1;
    wait_bit(0, 2, 1'b0, "to_qreq2");
    tick(63);
    check("to_before", timeout_err_o, 0);
    tick(1);
    check("to_flag", timeout_err_o, 1);
    check("to_dev", err_dev_o, 2);
    check("to_state", lp_state_o, 1);
    dev_en[2] = 1'b1;
    wait_state(3, "to_late_sleep");
    check("to_sticky", timeout_err_o, 1);
    check("to_sleep_icg", icg_enable_o, 4'b1011);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("to_cleared", timeout_err_o, 0);
    lpr = 1'b0;
    wait_state(0, "to_run");
    check("to_run_qreqn", qreqn_o, 4'hF);

    // Asynchronous reset in the middle of SLEEP.
    mask = 4'b0101; lpr = 1'b1;
    wait_state(3, "rs_sleep");
    check("rs_stopped", stopped_o, 4'b0101);
    check("rs_icg", icg_enable_o, 4'b1010);
    #1 reset = 1'b0;
    #1;
    check("rs_state", lp_state_o, 0);
    check("rs_qreqn", qreqn_o, 4'hF);
    check("rs_icg_now", icg_enable_o, 4'hF);
    check("rs_stopped_now", stopped_o, 0);
    tick(2);
    reset = 1'b1; lpr = 1'b0;
    tick(8);
    check("rs_after_state", lp_state_o, 0);
    check("rs_after_icg", icg_enable_o, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qchan_power_sequencer.md
Name: qchan_power_sequencer

Overview:
- Clock-domain-local Q-channel controller that puts NUM_DEV devices into quiescent state, one at a time in ascending index order, and wakes them in descending order.
- Each device gets its own qreqn, synchronized qacceptn/qactive and ICG enable.
- Generalises the single-device low-power controller so several FIFO channels can share one low-power request.
- Enforces strict Q-channel ordering, gates clocks only after acceptance, and flags handshake timeouts.

Parameters:
NUM_DEV, 4, number of managed devices (1..8)
SYNC_STAGES, 2, flip-flop synchronizer depth on qacceptn_i/qactive_i (>=2)
ICG_DELAY, 2, cycles between handshake completion and ICG change (>=1)
TIMEOUT_CYCLES, 64, wait cycles in QREQ/QEXIT before timeout_err_o sets

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
low_power_req_i  in  1  level request to enter low power
sleep_mask_i  in  NUM_DEV  devices to quiesce; sampled on leaving RUN
clr_err_i  in  1  clears timeout_err_o
qactive_i  in  NUM_DEV  device activity (async, synchronized internally)
qacceptn_i  in  NUM_DEV  device acceptance, active-low (async, synchronized internally)
qreqn_o  out  NUM_DEV  quiescence request, active-low, registered
icg_enable_o  out  NUM_DEV  clock-gate enable per device, registered
stopped_o  out  NUM_DEV  devices currently quiesced (qacceptn_sync low)
lp_state_o  out  3  FSM state: 0 RUN, 1 QREQ, 2 GATE, 3 SLEEP, 4 UNGATE, 5 QEXIT
timeout_err_o  out  1  sticky handshake timeout
err_dev_o  out  3  index of first device that timed out

Behaviour:
- Reset (reset=0, async):
  - state RUN; qreqn_o all 1; icg_enable_o all 1; stopped_o 0.
  - timeout_err_o 0; err_dev_o 0; synchronizers preset to qacceptn=1, qactive=0.
- Synchronization: qa_s/qx_s are the outputs of the SYNC_STAGES flops. FSM uses only synchronized values, so response lags an input by SYNC_STAGES cycles.
- RUN:
  - Leaves when low_power_req_i=1, sleep_mask_i!=0 and no masked device has qx_s=1.
  - Captures mask into mask_r, sets idx = lowest set bit, moves to QREQ.
  - Mask==0 means stay in RUN.
- QREQ:
  - qreqn_o[idx]=0 from the first QREQ cycle.
  - On qa_s[idx]=0: set stopped[idx].
    - If low_power_req_i=1, go to GATE.
    - If low_power_req_i=0 (abort), go to QEXIT with the same idx; the ICG is never dropped.
  - qreqn is never raised before acceptance (protocol rule), including on abort.
- GATE:
  - Counts ICG_DELAY cycles, then drives icg_enable_o[idx]=0 in the same cycle as the transition.
  - If low_power_req_i=0, go to UNGATE with the same idx.
  - Else if a higher masked index exists, idx = next one, go to QREQ.
  - Else go to SLEEP.
- SLEEP:
  - Holds all outputs.
  - Exits to UNGATE when low_power_req_i=0 or any stopped device has qx_s=1 (wakeup).
  - idx = highest stopped index.
- UNGATE: icg_enable_o[idx]=1 on entry, wait ICG_DELAY cycles, go to QEXIT.
- QEXIT:
  - qreqn_o[idx]=1.
  - On qa_s[idx]=1: clear stopped[idx].
    - If any stopped device remains, idx = next lower stopped index, go to UNGATE.
    - Else go to RUN.
- Wake-ups are never aborted: once UNGATE starts, all stopped devices are restored before RUN, even if low_power_req_i reasserts.
- Timeout:
  - A counter clears on every entry to QREQ/QEXIT.
  - When it reaches TIMEOUT_CYCLES, timeout_err_o=1 and err_dev_o=idx, only if timeout_err_o was 0.
  - The FSM keeps waiting; no protocol violation.
  - clr_err_i=1 clears the error next cycle; a simultaneous new timeout wins.
- Mask changes after RUN exit are ignored until the next RUN.
- Invariants:
  - At most one qreqn transition in flight.
  - icg_enable_o[i]=0 implies qreqn_o[i]=0 and stopped[i]=1.

Test Plan:
- Reset mid-SLEEP with mask 4'b0101 -> all outputs at reset values immediately, state 0, no glitch on icg_enable_o.
- Mask 4'b1011, low_power_req_i=1, devices accept after 3 cycles -> qreqn_o[0], [1], [3] fall in order; each icg drops ICG_DELAY=2 cycles after its acceptance; state 3; device 2 untouched.
- In SLEEP, qactive_i[1]=1 -> after 2 sync cycles, wake order 3,1,0; for each device, icg rises 2 cycles before qreqn rises; return to state 0 with stopped_o=0.
- low_power_req_i drops while device 1 is in QREQ -> qreqn_o[1] stays 0 until acceptance, then QEXIT without icg_enable_o[1] ever falling; device 0 then ungated.
- Device 2 never accepts -> after 64 cycles timeout_err_o=1, err_dev_o=2, FSM stays in QREQ; late acceptance resumes the sequence; clr_err_i clears the flag.
- Mask 0 or a masked qactive=1 at request -> stays in RUN, qreqn_o all 1.
